// File: rtl/sim_commit_checker.sv
// -----------------------------------------------------------------------------
// sim_commit_checker
//   Lockstep co-simulation checker. Golden retire records (pc, npc, insn) from
//   the ISS feeder are buffered in a FIFO and compared against up to NRET
//   in-order DUT commits per cycle. The first mismatching lane is reported and
//   match/miss statistics are kept.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ref_valid/ref_ready      golden record handshake
//   ref_pc/ref_npc/ref_insn  golden record payload
//   cmt_valid                DUT lane valids (thermometer, lane 0 = LSB)
//   cmt_pc/cmt_insn          DUT lane payloads, lane 0 in the LSBs
//   next_pc/next_pc_valid    npc of the FIFO head while running
//   synced, halted           status
//   mismatch, mm_*           one-cycle mismatch report for the lowest bad lane
//   err_underflow, err_early sticky error flags
//   match_cnt, miss_cnt      saturating lane statistics
// -----------------------------------------------------------------------------
module sim_commit_checker #(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter int              NRET     = 2,
  parameter int              DEPTH    = 16,
  parameter logic [XLEN-1:0] START_PC = 64'h8000_0000,
  parameter int              MODE     = 0,
  parameter int              CNTW     = 32,
  localparam int             LW       = (NRET > 1) ? $clog2(NRET) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ref_valid,
  output logic                 ref_ready,
  input  logic [XLEN-1:0]      ref_pc,
  input  logic [XLEN-1:0]      ref_npc,
  input  logic [ILEN-1:0]      ref_insn,
  input  logic [NRET-1:0]      cmt_valid,
  input  logic [NRET*XLEN-1:0] cmt_pc,
  input  logic [NRET*ILEN-1:0] cmt_insn,
  output logic [XLEN-1:0]      next_pc,
  output logic                 next_pc_valid,
  output logic                 synced,
  output logic                 halted,
  output logic                 mismatch,
  output logic [LW-1:0]        mm_lane,
  output logic [XLEN-1:0]      mm_exp_pc,
  output logic [ILEN-1:0]      mm_exp_insn,
  output logic [XLEN-1:0]      mm_got_pc,
  output logic                 err_underflow,
  output logic                 err_early,
  output logic [CNTW-1:0]      match_cnt,
  output logic [CNTW-1:0]      miss_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int KW = $clog2(NRET + 1);

  typedef enum logic [1:0] {S_SYNC, S_RUN, S_HALT} state_e;

  state_e state, state_d;

  logic [XLEN-1:0] fifo_pc   [DEPTH];
  logic [XLEN-1:0] fifo_npc  [DEPTH];
  logic [ILEN-1:0] fifo_insn [DEPTH];
  logic [AW-1:0]   head;
  logic [CW-1:0]   count;
  logic [AW-1:0]   tail;

  // Lane comparison results
  logic [KW-1:0]   k;
  logic [NRET-1:0] lane_act, lane_mm;
  logic            any_mm;
  logic [LW-1:0]   mm_idx;
  logic [XLEN-1:0] mm_exp_pc_c, mm_got_pc_c;
  logic [ILEN-1:0] mm_exp_insn_c;
  logic [KW-1:0]   n_match, n_miss;
  logic            underflow;

  // Next-state actions
  logic            do_push, set_uf, set_early, set_sync, rep_mm;
  logic [KW-1:0]   pop_n, inc_match, inc_miss;

  function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] a,
                                              input logic [KW-1:0]   b);
    logic [CNTW:0] s;
    s = {1'b0, a} + (CNTW+1)'(b);
    return s[CNTW] ? '1 : s[CNTW-1:0];
  endfunction

  assign tail      = head + count[AW-1:0];
  assign underflow = CW'(k) > count;

  // Only the leading contiguous run of valid lanes takes part; lane i is
  // checked against the i-th buffered record after the head.
  always_comb begin : lane_compare
    logic          lead;
    logic [AW-1:0] idx;
    // NOTE: every variable gets a default before any conditional write so no
    // latch is inferred when a branch does not assign it.
    lead          = 1'b1;
    idx           = '0;
    k             = '0;
    lane_act      = '0;
    lane_mm       = '0;
    any_mm        = 1'b0;
    mm_idx        = '0;
    mm_exp_pc_c   = '0;
    mm_exp_insn_c = '0;
    mm_got_pc_c   = '0;
    n_match       = '0;
    n_miss        = '0;
    for (int i = 0; i < NRET; i++) begin
      lead        = lead & cmt_valid[i];
      lane_act[i] = lead;
      if (lead) k = KW'(i + 1);
    end
    for (int i = 0; i < NRET; i++) begin
      idx        = head + AW'(i);
      lane_mm[i] = lane_act[i] &&
                   ((fifo_pc[idx]   != cmt_pc[i*XLEN +: XLEN]) ||
                    (fifo_insn[idx] != cmt_insn[i*ILEN +: ILEN]));
      if (lane_act[i] && !lane_mm[i]) n_match = n_match + KW'(1);
      if (lane_mm[i]) begin
        n_miss = n_miss + KW'(1);
        if (!any_mm) begin
          any_mm        = 1'b1;
          mm_idx        = LW'(i);
          mm_exp_pc_c   = fifo_pc[idx];
          mm_exp_insn_c = fifo_insn[idx];
          mm_got_pc_c   = cmt_pc[i*XLEN +: XLEN];
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin : state_reg
    if (rst) state <= S_SYNC;
    else     state <= state_d;
  end

  // Next state and per-cycle actions
  always_comb begin : next_state
    state_d   = state;
    do_push   = 1'b0;
    set_uf    = 1'b0;
    set_early = 1'b0;
    set_sync  = 1'b0;
    rep_mm    = 1'b0;
    pop_n     = '0;
    inc_match = '0;
    inc_miss  = '0;
    unique case (state)
      S_SYNC: begin
        set_early = |cmt_valid;
        // Records before START_PC are consumed and dropped.
        if (ref_valid && (ref_pc == START_PC)) begin
          do_push  = 1'b1;
          set_sync = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        do_push = ref_valid && ref_ready;
        if (underflow) begin
          set_uf  = 1'b1;
          state_d = S_HALT;
        end else begin
          rep_mm = any_mm;
          if ((MODE == 0) && any_mm) begin
            // Retire only the lanes ahead of the failing one, then stop.
            pop_n     = KW'(mm_idx);
            inc_match = KW'(mm_idx);
            inc_miss  = KW'(1);
            state_d   = S_HALT;
          end else begin
            pop_n     = k;
            inc_match = n_match;
            inc_miss  = n_miss;
          end
        end
      end
      S_HALT:  ;
      default: state_d = S_SYNC;
    endcase
  end

  // Outputs decoded from registered state only (plus reset masking)
  always_comb begin : outputs
    ref_ready     = 1'b0;
    next_pc_valid = 1'b0;
    next_pc       = '0;
    halted        = (state == S_HALT);
    unique case (state)
      S_SYNC: ref_ready = !rst;
      S_RUN: begin
        ref_ready     = !rst && (count < CW'(DEPTH));
        next_pc_valid = (count != '0);
        if (count != '0) next_pc = fifo_npc[head];
      end
      default: ;
    endcase
  end

  // NOTE: the record storage has no reset; head/count define which entries
  // are live, so stale contents are never observed.
  always_ff @(posedge clk) begin : fifo_write
    if (do_push) begin
      fifo_pc[tail]   <= ref_pc;
      fifo_npc[tail]  <= ref_npc;
      fifo_insn[tail] <= ref_insn;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin : datapath
    if (rst) begin
      head          <= '0;
      count         <= '0;
      synced        <= 1'b0;
      mismatch      <= 1'b0;
      mm_lane       <= '0;
      mm_exp_pc     <= '0;
      mm_exp_insn   <= '0;
      mm_got_pc     <= '0;
      err_underflow <= 1'b0;
      err_early     <= 1'b0;
      match_cnt     <= '0;
      miss_cnt      <= '0;
    end else begin
      head     <= head + AW'(pop_n);
      count    <= count + CW'(do_push) - CW'(pop_n);
      mismatch <= rep_mm;
      if (set_sync)  synced        <= 1'b1;
      if (set_uf)    err_underflow <= 1'b1;
      if (set_early) err_early     <= 1'b1;
      if (rep_mm) begin
        mm_lane     <= mm_idx;
        mm_exp_pc   <= mm_exp_pc_c;
        mm_exp_insn <= mm_exp_insn_c;
        mm_got_pc   <= mm_got_pc_c;
      end
      match_cnt <= sat_add(match_cnt, inc_match);
      miss_cnt  <= sat_add(miss_cnt, inc_miss);
    end
  end

endmodule

// File: tb/tb_sim_commit_checker.sv
module tb_sim_commit_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Two instances: index 0 halts on mismatch, index 1 counts and continues
  logic         rst           [2];
  logic         ref_valid     [2];
  logic         ref_ready     [2];
  logic [63:0]  ref_pc        [2];
  logic [63:0]  ref_npc       [2];
  logic [31:0]  ref_insn      [2];
  logic [1:0]   cmt_valid     [2];
  logic [127:0] cmt_pc        [2];
  logic [63:0]  cmt_insn      [2];
  logic [63:0]  next_pc       [2];
  logic         next_pc_valid [2];
  logic         synced        [2];
  logic         halted        [2];
  logic         mismatch      [2];
  logic [0:0]   mm_lane       [2];
  logic [63:0]  mm_exp_pc     [2];
  logic [31:0]  mm_exp_insn   [2];
  logic [63:0]  mm_got_pc     [2];
  logic         err_underflow [2];
  logic         err_early     [2];
  logic [31:0]  match_cnt     [2];
  logic [31:0]  miss_cnt      [2];

  sim_commit_checker #(.MODE(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .ref_valid(ref_valid[0]), .ref_ready(ref_ready[0]),
    .ref_pc(ref_pc[0]), .ref_npc(ref_npc[0]), .ref_insn(ref_insn[0]),
    .cmt_valid(cmt_valid[0]), .cmt_pc(cmt_pc[0]), .cmt_insn(cmt_insn[0]),
    .next_pc(next_pc[0]), .next_pc_valid(next_pc_valid[0]), .synced(synced[0]),
    .halted(halted[0]), .mismatch(mismatch[0]), .mm_lane(mm_lane[0]),
    .mm_exp_pc(mm_exp_pc[0]), .mm_exp_insn(mm_exp_insn[0]), .mm_got_pc(mm_got_pc[0]),
    .err_underflow(err_underflow[0]), .err_early(err_early[0]),
    .match_cnt(match_cnt[0]), .miss_cnt(miss_cnt[0])
  );

  sim_commit_checker #(.MODE(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .ref_valid(ref_valid[1]), .ref_ready(ref_ready[1]),
    .ref_pc(ref_pc[1]), .ref_npc(ref_npc[1]), .ref_insn(ref_insn[1]),
    .cmt_valid(cmt_valid[1]), .cmt_pc(cmt_pc[1]), .cmt_insn(cmt_insn[1]),
    .next_pc(next_pc[1]), .next_pc_valid(next_pc_valid[1]), .synced(synced[1]),
    .halted(halted[1]), .mismatch(mismatch[1]), .mm_lane(mm_lane[1]),
    .mm_exp_pc(mm_exp_pc[1]), .mm_exp_insn(mm_exp_insn[1]), .mm_got_pc(mm_got_pc[1]),
    .err_underflow(err_underflow[1]), .err_early(err_early[1]),
    .match_cnt(match_cnt[1]), .miss_cnt(miss_cnt[1])
  );

  typedef enum int {
    SG_READY, SG_NPC, SG_NPCV, SG_SYNCED, SG_HALTED, SG_MISMATCH, SG_MM_LANE,
    SG_MM_EPC, SG_MM_EINSN, SG_MM_GPC, SG_ERR_UF, SG_ERR_EARLY, SG_MATCH, SG_MISS
  } sig_e;

  typedef struct packed {
    int          cyc;
    logic        inst;
    sig_e        sig;
    logic [63:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_mm  = 0;

  task automatic check(input string what, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mm++;
      $display("FAIL %s cyc %0d: got 0x%0h expected 0x%0h", what, cyc, got, exp);
    end
  endtask

  // Golden stream: record n sits at 0x80000000+4n and holds addi x1,x0,n
  function automatic logic [63:0] gpc(input int n);
    return 64'h8000_0000 + 64'(4 * n);
  endfunction

  function automatic logic [31:0] gins(input int n);
    return 32'h0000_0093 | (32'(n) << 20);
  endfunction

  function automatic logic [63:0] probe(input logic d, input sig_e s);
    int i;
    i = int'(d);
    case (s)
      SG_READY:     return 64'(ref_ready[i]);
      SG_NPC:       return next_pc[i];
      SG_NPCV:      return 64'(next_pc_valid[i]);
      SG_SYNCED:    return 64'(synced[i]);
      SG_HALTED:    return 64'(halted[i]);
      SG_MISMATCH:  return 64'(mismatch[i]);
      SG_MM_LANE:   return 64'(mm_lane[i]);
      SG_MM_EPC:    return mm_exp_pc[i];
      SG_MM_EINSN:  return 64'(mm_exp_insn[i]);
      SG_MM_GPC:    return mm_got_pc[i];
      SG_ERR_UF:    return 64'(err_underflow[i]);
      SG_ERR_EARLY: return 64'(err_early[i]);
      SG_MATCH:     return 64'(match_cnt[i]);
      default:      return 64'(miss_cnt[i]);
    endcase
  endfunction

  // Scoreboard push: expectation applies to the outputs seen this cycle
  task automatic expect_sig(input int d, input sig_e s, input logic [63:0] v);
    exp_t e;
    e.cyc  = cyc;
    e.inst = d[0];
    e.sig  = s;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, away from the active edge
  initial begin : monitor
    exp_t        e;
    logic [63:0] got;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e   = sb_q.pop_front();
        got = probe(e.inst, e.sig);
        if (e.cyc != cyc) begin
          n_mm++;
          $display("FAIL %s dut%0d: due cyc %0d checked late at cyc %0d",
                   e.sig.name(), e.inst, e.cyc, cyc);
        end
        check($sformatf("%s dut%0d", e.sig.name(), e.inst), got, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in(input int d);
    ref_valid[d] = 1'b0;
    ref_pc[d]    = '0;
    ref_npc[d]   = '0;
    ref_insn[d]  = '0;
    cmt_valid[d] = '0;
    cmt_pc[d]    = '0;
    cmt_insn[d]  = '0;
  endtask

  task automatic send_ref(input int d, input logic [63:0] pc, input logic [31:0] insn);
    ref_valid[d] = 1'b1;
    ref_pc[d]    = pc;
    ref_npc[d]   = pc + 64'd4;
    ref_insn[d]  = insn;
  endtask

  task automatic no_ref(input int d);
    ref_valid[d] = 1'b0;
  endtask

  task automatic commit(input int d, input logic [1:0] v,
                        input logic [63:0] pc0, input logic [31:0] in0,
                        input logic [63:0] pc1, input logic [31:0] in1);
    cmt_valid[d] = v;
    cmt_pc[d]    = {pc1, pc0};
    cmt_insn[d]  = {in1, in0};
  endtask

  task automatic no_cmt(input int d);
    cmt_valid[d] = '0;
  endtask

  task automatic exp_reset(input int d, input logic rdy);
    expect_sig(d, SG_READY, 64'(rdy));
    expect_sig(d, SG_SYNCED, 0);
    expect_sig(d, SG_HALTED, 0);
    expect_sig(d, SG_MISMATCH, 0);
    expect_sig(d, SG_NPCV, 0);
    expect_sig(d, SG_NPC, 0);
    expect_sig(d, SG_MM_LANE, 0);
    expect_sig(d, SG_MM_EPC, 0);
    expect_sig(d, SG_MM_EINSN, 0);
    expect_sig(d, SG_MM_GPC, 0);
    expect_sig(d, SG_ERR_UF, 0);
    expect_sig(d, SG_ERR_EARLY, 0);
    expect_sig(d, SG_MATCH, 0);
    expect_sig(d, SG_MISS, 0);
  endtask

  // One-cycle reset; outputs checked while rst is still high
  task automatic reset_pulse(input int d);
    rst[d] = 1'b1;
    clear_in(d);
    tick();
    exp_reset(d, 1'b0);
    @(negedge clk);
    #1;
    rst[d] = 1'b0;
  endtask

  initial begin : timeout
    #200000;
    n_mm++;
    $display("FAIL timeout: stimulus did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mm);
    $finish;
  end

  initial begin : stimulus
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      clear_in(d);
    end

    // ---------------- instance 0: halt on mismatch ----------------
    reset_pulse(0);

    // Pre-START_PC records are dropped, then sync on 0x80000000
    send_ref(0, 64'h1000, 32'h13); tick(); expect_sig(0, SG_SYNCED, 0);
    send_ref(0, 64'h1004, 32'h13); tick(); expect_sig(0, SG_SYNCED, 0);
    expect_sig(0, SG_READY, 1);
    send_ref(0, gpc(0), gins(0)); tick();
    expect_sig(0, SG_SYNCED, 1); expect_sig(0, SG_NPCV, 1); expect_sig(0, SG_NPC, gpc(1));
    send_ref(0, gpc(1), gins(1)); tick();
    expect_sig(0, SG_NPC, gpc(1)); expect_sig(0, SG_READY, 1);
    no_ref(0);

    // Two-lane matching commit drains both records
    commit(0, 2'b11, gpc(0), gins(0), gpc(1), gins(1)); tick();
    expect_sig(0, SG_MATCH, 2); expect_sig(0, SG_MISMATCH, 0);
    expect_sig(0, SG_NPCV, 0); expect_sig(0, SG_NPC, 0); expect_sig(0, SG_HALTED, 0);
    no_cmt(0); tick();
    expect_sig(0, SG_MATCH, 2);

    // Lane 1 insn mismatch halts after retiring lane 0
    reset_pulse(0);
    send_ref(0, gpc(0), gins(0)); tick();
    send_ref(0, gpc(1), gins(1)); tick();
    no_ref(0);
    commit(0, 2'b11, gpc(0), gins(0), gpc(1), 32'h0000_0013); tick();
    expect_sig(0, SG_MISMATCH, 1); expect_sig(0, SG_MM_LANE, 1);
    expect_sig(0, SG_MM_EPC, gpc(1)); expect_sig(0, SG_MM_EINSN, 64'h0010_0093);
    expect_sig(0, SG_MM_GPC, gpc(1)); expect_sig(0, SG_MATCH, 1);
    expect_sig(0, SG_HALTED, 1); expect_sig(0, SG_READY, 0);
    no_cmt(0); tick();
    expect_sig(0, SG_MISMATCH, 0); expect_sig(0, SG_HALTED, 1);
    // Commits and records are ignored while halted
    send_ref(0, gpc(2), gins(2));
    commit(0, 2'b01, gpc(1), gins(1), 64'd0, 32'd0); tick();
    expect_sig(0, SG_MATCH, 1); expect_sig(0, SG_READY, 0); expect_sig(0, SG_MISMATCH, 0);
    no_cmt(0); no_ref(0);

    // Fill to DEPTH, then commit two lanes while the feeder is still valid
    reset_pulse(0);
    for (int n = 0; n < 16; n++) begin
      send_ref(0, gpc(n), gins(n));
      tick();
    end
    expect_sig(0, SG_READY, 0); expect_sig(0, SG_NPC, gpc(1));
    send_ref(0, gpc(16), gins(16));
    commit(0, 2'b11, gpc(0), gins(0), gpc(1), gins(1)); tick();
    expect_sig(0, SG_MATCH, 2); expect_sig(0, SG_READY, 1); expect_sig(0, SG_NPC, gpc(3));
    no_ref(0);
    // Exactly 14 records must remain
    for (int p = 0; p < 7; p++) begin
      commit(0, 2'b11, gpc(2 + 2*p), gins(2 + 2*p), gpc(3 + 2*p), gins(3 + 2*p));
      tick();
    end
    expect_sig(0, SG_MATCH, 16); expect_sig(0, SG_NPCV, 0);
    expect_sig(0, SG_ERR_UF, 0); expect_sig(0, SG_MISMATCH, 0);
    no_cmt(0);

    // Underflow: two commits against one buffered record
    reset_pulse(0);
    send_ref(0, gpc(0), gins(0)); tick();
    no_ref(0);
    commit(0, 2'b11, gpc(0), gins(0), gpc(1), gins(1)); tick();
    expect_sig(0, SG_ERR_UF, 1); expect_sig(0, SG_HALTED, 1);
    expect_sig(0, SG_MATCH, 0); expect_sig(0, SG_MISMATCH, 0);
    no_cmt(0);
    reset_pulse(0);
    tick();
    exp_reset(0, 1'b1);

    // ---------------- instance 1: count and continue ----------------
    reset_pulse(1);
    commit(1, 2'b01, gpc(0), gins(0), 64'd0, 32'd0); tick();
    expect_sig(1, SG_ERR_EARLY, 1); expect_sig(1, SG_SYNCED, 0); expect_sig(1, SG_MATCH, 0);
    no_cmt(1);
    send_ref(1, gpc(0), gins(0)); tick();
    send_ref(1, gpc(1), gins(1)); tick();
    no_ref(1);
    commit(1, 2'b11, gpc(0), gins(0), gpc(1), 32'h0000_0013); tick();
    expect_sig(1, SG_MISMATCH, 1); expect_sig(1, SG_MM_LANE, 1);
    expect_sig(1, SG_MM_EINSN, 64'h0010_0093); expect_sig(1, SG_MISS, 1);
    expect_sig(1, SG_MATCH, 1); expect_sig(1, SG_HALTED, 0); expect_sig(1, SG_NPCV, 0);
    no_cmt(1);
    for (int n = 2; n < 8; n++) begin
      send_ref(1, gpc(n), gins(n));
      tick();
      if (n == 2) expect_sig(1, SG_MISMATCH, 0);
    end
    expect_sig(1, SG_NPC, gpc(3)); expect_sig(1, SG_READY, 1);
    no_ref(1);
    for (int p = 0; p < 3; p++) begin
      commit(1, 2'b11, gpc(2 + 2*p), gins(2 + 2*p), gpc(3 + 2*p), gins(3 + 2*p));
      tick();
    end
    expect_sig(1, SG_MATCH, 7); expect_sig(1, SG_MISS, 1);
    expect_sig(1, SG_HALTED, 0); expect_sig(1, SG_MISMATCH, 0); expect_sig(1, SG_NPCV, 0);
    // Non-thermometer valid: lane 0 idle means no lanes count
    commit(1, 2'b10, 64'd0, 32'd0, gpc(8), gins(8)); tick();
    expect_sig(1, SG_MATCH, 7); expect_sig(1, SG_MISS, 1);
    expect_sig(1, SG_ERR_UF, 0); expect_sig(1, SG_HALTED, 0);
    no_cmt(1);

    tick(); tick(); tick();

    // Final state of both instances, checked directly
    check("dut1 match_cnt final", 64'(match_cnt[1]), 64'd7);
    check("dut1 miss_cnt final", 64'(miss_cnt[1]), 64'd1);
    check("dut1 halted final", 64'(halted[1]), 64'd0);
    check("dut1 err_underflow final", 64'(err_underflow[1]), 64'd0);
    check("dut0 ref_ready final", 64'(ref_ready[0]), 64'd1);
    check("dut0 synced final", 64'(synced[0]), 64'd0);
    check("dut0 halted final", 64'(halted[0]), 64'd0);

    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_cmp++;
      n_mm++;
      $display("FAIL %s dut%0d: expectation for cyc %0d never checked", e.sig.name(), e.inst, e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mm);
    $finish;
  end

endmodule

// File: doc/sim_commit_checker.md
Name: sim_commit_checker

Overview:
- Lockstep co-simulation checker between the DUT retire stage and the golden ISS trace.
- Buffers golden retire records (pc, npc, insn) in a FIFO, fed by a DPI-side feeder through a valid/ready port.
- Checks up to NRET in-order DUT commits per cycle against the buffered records; reports the first mismatch and keeps statistics.
- Generalises single-instruction PC checking to multi-lane retire, buffered trace, configurable stop/continue mode and sync-to-start.

Parameters:
- XLEN, 64, PC width.
- ILEN, 32, instruction width.
- NRET, 2, DUT commit lanes per cycle (>=1).
- DEPTH, 16, golden FIFO entries (power of 2, >= NRET).
- START_PC, 64'h80000000, first PC checked; earlier golden records are discarded.
- MODE, 0, 0 = halt on first mismatch, 1 = count and continue.
- CNTW, 32, statistics counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- ref_valid  in  1  golden record valid.
- ref_ready  out  1  checker accepts golden record.
- ref_pc  in  XLEN  golden retired PC.
- ref_npc  in  XLEN  golden next PC.
- ref_insn  in  ILEN  golden instruction.
- cmt_valid  in  NRET  DUT lane valid, thermometer (lane i valid => lanes <i valid).
- cmt_pc  in  NRET*XLEN  DUT PCs, lane 0 in LSBs.
- cmt_insn  in  NRET*ILEN  DUT instructions.
- next_pc  out  XLEN  npc of FIFO head; 0 when empty.
- next_pc_valid  out  1  FIFO non-empty in RUN.
- synced  out  1  START_PC record captured.
- halted  out  1  HALT state.
- mismatch  out  1  one-cycle pulse, >=1 lane mismatched.
- mm_lane  out  max(1,$clog2(NRET))  first mismatching lane.
- mm_exp_pc  out  XLEN  expected PC of that lane.
- mm_exp_insn  out  ILEN  expected insn.
- mm_got_pc  out  XLEN  DUT PC of that lane.
- err_underflow  out  1  sticky: commits exceeded buffered records.
- err_early  out  1  sticky: commit seen before synced.
- match_cnt  out  CNTW  matched lanes, saturating.
- miss_cnt  out  CNTW  mismatched lanes, saturating.

Behaviour:
- Reset: all outputs 0, FIFO empty, state SYNC. Same on rst asserted mid-operation; in-flight inputs dropped that cycle.
- SYNC:
  - ref_ready=1.
  - Record with ref_pc!=START_PC: consumed and discarded.
  - Record with ref_pc==START_PC: pushed, synced<=1, go RUN.
  - Any cmt_valid: err_early<=1; commits ignored.
- RUN:
  - ref_ready = (count<DEPTH), computed from registered count; push on ref_valid&&ref_ready.
  - k = popcount(cmt_valid). If k>count (pre-push count): err_underflow<=1, go HALT, nothing popped.
  - Otherwise lane i compares cmt_pc/cmt_insn against entry head+i (wrap mod DEPTH). Match requires both pc and insn equal.
  - Any mismatch: next cycle mismatch=1; mm_* report lowest mismatching lane j.
  - MODE 0, mismatch: pop j entries, match_cnt+=j, go HALT.
  - MODE 1, or no mismatch: pop k entries; match_cnt += matched lanes, miss_cnt += mismatched lanes.
  - Push and pop in the same cycle allowed: count <= count + push - pop. A full FIFO cannot push even if popping.
  - Non-thermometer cmt_valid: only the leading contiguous valid lanes counted.
- HALT: ref_ready=0, commits ignored, halted=1, counters frozen until rst.
- Counters saturate at 2^CNTW-1, no wrap.
- All outputs registered; one-cycle latency from commit to mismatch/counters.

Test Plan:
- Feed records pc 0x1000, 0x1004, 0x80000000, 0x80000004 -> first two dropped, synced=1 after third, count=2.
- RUN, NRET=2, DUT commits 0x80000000 and 0x80000004 with matching insns in one cycle -> match_cnt=2, mismatch=0, FIFO empty, next_pc_valid=0.
- MODE0, lane1 insn 0x00000013 vs expected 0x00100093 -> mismatch pulse, mm_lane=1, mm_exp_insn=0x00100093, match_cnt=1, halted=1, ref_ready=0.
- MODE1, same stimulus, then 3 correct cycles -> miss_cnt=1, halted=0, checking continues, match_cnt=7.
- DEPTH=16 filled and held full while a 2-lane commit occurs with ref_valid=1 -> no push that cycle, count=14, ref_ready=1 next cycle.
- Two commits with one buffered record -> err_underflow=1, halted=1. Then rst for 1 cycle -> all outputs 0, state SYNC.
